demux_stream_n: RTL and testbench

//  Registered, parametrised 1-to-NCH demultiplexer with valid/ready handshake on every port.

---
 rtl/demux_stream_n.sv | 110 +++++++++++
 tb/tb_demux_stream_n.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_n.sv
// rtl/demux_stream_n.sv - registered 1-to-NCH stream demultiplexer with broadcast and drop counting
module demux_stream_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [CNT_W-1:0]     drop_cnt
);

    // Per-channel holding registers; data is kept at zero whenever the channel is empty.
    logic [WIDTH-1:0] r_data [NCH];
    logic [NCH-1:0]   r_valid;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [NCH-1:0]   w_free;
    logic [NCH-1:0]   w_sel_hot;
    logic [NCH-1:0]   w_load;
    logic             w_sel_hit;
    logic             w_sel_free;
    logic             w_all_free;
    logic             w_accept;
    logic             w_drop;

    // One-hot decode of the select; an out-of-range select leaves every bit clear.
    always_comb begin
        w_sel_hot = '0;
        for (int k = 0; k < NCH; k++) begin
            w_sel_hot[k] = ({1'b0, in_sel} == (SEL_W+1)'(k));
        end
    end

    // A channel can take a word when it is empty or is being drained this cycle.
    always_comb begin
        w_free     = ~r_valid | out_ready;
        w_all_free = &w_free;
        w_sel_hit  = |w_sel_hot;
        w_sel_free = |(w_sel_hot & w_free);
    end

    // Acceptance: broadcast needs every channel, unicast only its target, a bad select always goes.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = w_all_free;
        end else if (w_sel_hit) begin
            in_ready = w_sel_free;
        end
    end

    // Work out which channels load and whether the accepted word is discarded.
    always_comb begin
        w_accept = in_valid & in_ready;
        w_load   = '0;
        if (w_accept) begin
            w_load = in_bcast ? {NCH{1'b1}} : w_sel_hot;
        end
        w_drop   = w_accept & ~in_bcast & ~w_sel_hit;
    end

    // Channel registers: a load beats a pop so a full channel streams one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (r_valid[k] && out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end
            end
        end
    end

    // Saturating count of words thrown away for an out-of-range select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_pack
            assign out_data[g*WIDTH +: WIDTH] = r_data[g];
        end
    endgenerate

    assign out_valid = r_valid;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_demux_stream_n.sv
// tb/tb_demux_stream_n.sv - self-checking bench for demux_stream_n
module tb_demux_stream_n;

    logic        clk;
    logic        rst;

    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  drop_cnt;

    logic [7:0]  d_in_data;
    logic [1:0]  d_in_sel;
    logic        d_in_bcast;
    logic        d_in_valid;
    logic        d_in_ready;
    logic [23:0] d_out_data;
    logic [2:0]  d_out_valid;
    logic [2:0]  d_out_ready;
    logic [7:0]  d_drop_cnt;

    demux_stream_n #(.WIDTH(8), .NCH(4), .SEL_W(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_cnt(drop_cnt)
    );

    demux_stream_n #(.WIDTH(8), .NCH(3), .SEL_W(2), .CNT_W(8)) u_drop (
        .clk(clk), .rst(rst),
        .in_data(d_in_data), .in_sel(d_in_sel), .in_bcast(d_in_bcast),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .drop_cnt(d_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef logic [7:0] byteq_t[$];
    byteq_t sb[4];

    typedef struct {
        logic       v;
        logic       b;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle on the 4-channel instance: drive, sample at negedge against the scoreboard, update it.
    task automatic step(input logic v, input logic b, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] rdy, output logic got_rdy, output logic [3:0] got_ov);
        logic [3:0] free;
        logic       er;
        logic [7:0] exp_slice;
        in_valid  = v;
        in_bcast  = b;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        for (int k = 0; k < 4; k++) free[k] = (sb[k].size() == 0) || rdy[k];
        er = b ? (&free) : free[s];
        got_rdy = in_ready;
        got_ov  = out_valid;
        chk("sb_in_ready", {31'b0, in_ready}, {31'b0, er});
        for (int k = 0; k < 4; k++) begin
            exp_slice = (sb[k].size() != 0) ? sb[k][0] : 8'h00;
            chk($sformatf("sb_valid%0d", k), {31'b0, out_valid[k]}, {31'b0, (sb[k].size() != 0)});
            chk($sformatf("sb_data%0d", k), {24'b0, out_data[k*8 +: 8]}, {24'b0, exp_slice});
        end
        chk("drop_cnt_main", {24'b0, drop_cnt}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            if ((sb[k].size() != 0) && rdy[k]) void'(sb[k].pop_front());
        end
        if (v && er) begin
            for (int k = 0; k < 4; k++) begin
                if (b || (s == 2'(k))) sb[k].push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic       gr;
    logic [3:0] gov;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b0000, 1'b0, 4'b0100};
        vecs[2]  = '{1'b1, 1'b0, 2'd2, 8'h11, 4'b0000, 1'b0, 4'b0100};
        vecs[3]  = '{1'b1, 1'b0, 2'd1, 8'h22, 4'b0000, 1'b1, 4'b0100};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 8'h33, 4'b0100, 1'b1, 4'b0110};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b0000, 1'b0, 4'b0110};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0110};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'h44, 4'b0000, 1'b1, 4'b0000};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 8'h3C, 4'b0000, 1'b0, 4'b0001};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 8'h3C, 4'b0001, 1'b1, 4'b0001};
        vecs[10] = '{1'b0, 1'b0, 2'd3, 8'h00, 4'b0000, 1'b0, 4'b1111};
        vecs[11] = '{1'b1, 1'b1, 2'd0, 8'h55, 4'b1110, 1'b0, 4'b1111};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0001};

        rst = 1'b1;
        in_valid = 1'b0; in_bcast = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
        d_in_valid = 1'b0; d_in_bcast = 1'b0; d_in_sel = 2'd0; d_in_data = 8'h00; d_out_ready = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {28'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
        @(posedge clk);
        #1;

        // Unicast, backpressure and broadcast vectors
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].v, vecs[i].b, vecs[i].s, vecs[i].d, vecs[i].rdy, gr, gov);
            chk($sformatf("vec%0d_in_ready", i), {31'b0, gr}, {31'b0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_out_valid", i), {28'b0, gov}, {28'b0, vecs[i].exp_ov});
        end
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, gr, gov);

        // Streaming 100 words into channel 1 at full rate
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 2'd1, 8'($urandom_range(0, 255)), 4'b0010, gr, gov);
            chk("stream_in_ready", {31'b0, gr}, 32'd1);
        end
        step(1'b0, 1'b0, 2'd1, 8'h00, 4'b0010, gr, gov);
        chk("stream_last_valid", {28'b0, gov}, 32'b0010);
        step(1'b0, 1'b0, 2'd1, 8'h00, 4'b0010, gr, gov);
        chk("stream_drained", {28'b0, gov}, 32'd0);

        // Out-of-range select on the 3-channel instance
        d_in_valid = 1'b1; d_in_sel = 2'd3; d_in_data = 8'h77; d_out_ready = 3'b000;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("drop_in_ready", {31'b0, d_in_ready}, 32'd1);
            chk("drop_out_valid", {29'b0, d_out_valid}, 32'd0);
            chk("drop_cnt", {24'b0, d_drop_cnt}, (i > 255) ? 32'd255 : 32'(i));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("drop_cnt_sat", {24'b0, d_drop_cnt}, 32'd255);
        @(posedge clk);
        #1;
        d_in_sel = 2'd0; d_in_data = 8'h9E;
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        @(negedge clk);
        chk("drop_ch0_loaded", {29'b0, d_out_valid}, 32'b001);
        chk("drop_ch0_data", {8'b0, d_out_data}, 32'h00009E);
        @(posedge clk);
        #1;

        // Reset mid-stream with words held in both instances
        step(1'b1, 1'b0, 2'd2, 8'hC3, 4'b0000, gr, gov);
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {28'b0, out_valid}, 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_drop_valid", {29'b0, d_out_valid}, 32'd0);
        chk("midrst_drop_data", {8'b0, d_out_data}, 32'd0);
        chk("midrst_drop_cnt", {24'b0, d_drop_cnt}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) sb[k].delete();
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, gr, gov);
        chk("post_rst_valid", {28'b0, gov}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
